// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared encodings for the instruction fetch stage
// Next-PC operations, fetch FSM states and sticky fetch error codes.
package if_stage_pkg;

    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    typedef enum logic [1:0] {
        ST_RESET = 2'b00,
        ST_FETCH = 2'b01,
        ST_ISSUE = 2'b10,
        ST_HALT  = 2'b11
    } fetch_state_t;

    localparam logic [1:0] FERR_NONE     = 2'b00;
    localparam logic [1:0] FERR_MISALIGN = 2'b01;
    localparam logic [1:0] FERR_TIMEOUT  = 2'b10;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/if_stage_npc.sv
// rtl/if_stage_npc.sv - combinational next-PC computation
// All sums wrap modulo 2^32; JALR clears bit 0 of the target.
module npc
    import if_stage_pkg::*;
(
    input  logic [31:0] PC,
    input  logic [2:0]  NPCOp,
    input  logic [31:0] IMM,
    input  logic [31:0] RS1,
    output logic [31:0] NPC
);

    logic [31:0] jalr_sum;

    assign jalr_sum = RS1 + IMM;

    always_comb begin
        NPC = PC + 32'd4;
        case (NPCOp)
            NPC_BRANCH, NPC_JUMP: NPC = PC + IMM;
            NPC_JALR:             NPC = {jalr_sum[31:1], 1'b0};
            default:              NPC = PC + 32'd4;
        endcase
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with timeout and misalignment halt
// FETCH requests imem until ready, ISSUE holds the instruction until advance.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          IMEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic [2:0]  NPCOp,
    input  logic [31:0] IMM,
    input  logic [31:0] RS1,
    input  logic        advance,
    output logic [31:0] PC,
    output logic [31:0] PC4,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [1:0]  fetch_err
);

    localparam int CW = $clog2(IMEM_TIMEOUT + 1);

    fetch_state_t  state, state_nx;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   npc_val;
    logic          npc_misaligned;
    logic          timeout_hit;

    npc u_npc (
        .PC    (PC),
        .NPCOp (NPCOp),
        .IMM   (IMM),
        .RS1   (RS1),
        .NPC   (npc_val)
    );

    assign npc_misaligned = |npc_val[1:0];
    // Fires on the IMEM_TIMEOUT-th consecutive unready cycle.
    assign timeout_hit    = (wait_cnt == CW'(IMEM_TIMEOUT - 1));
    assign imem_addr      = PC;
    assign PC4            = PC + 32'd4;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_RESET;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state)
            ST_RESET: state_nx = ST_FETCH;
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    state_nx = ST_ISSUE;
                end else if (timeout_hit) begin
                    state_nx = ST_HALT;
                end
            end
            ST_ISSUE: begin
                instr_valid = 1'b1;
                if (advance) begin
                    state_nx = npc_misaligned ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT:  state_nx = ST_HALT;
            default:  state_nx = ST_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            PC        <= RESET_PC;
            instr     <= NOP_INSTR;
            fetch_err <= FERR_NONE;
            wait_cnt  <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_ready) begin
                        instr    <= imem_rdata;
                        wait_cnt <= '0;
                    end else if (timeout_hit) begin
                        fetch_err <= FERR_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (advance) begin
                        if (npc_misaligned) begin
                            fetch_err <= FERR_MISALIGN;
                        end else begin
                            PC <= npc_val;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - randomized self-checking bench for if_stage
// A transaction-level model predicts fetch addresses, issued words and errors.
module tb_if_stage;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_ready = 1'b0;
    logic [2:0]  npc_op = '0;
    logic [31:0] imm = '0;
    logic [31:0] rs1 = '0;
    logic        advance = 1'b0;

    logic        imem_req, w_req;
    logic [31:0] imem_addr, w_addr;
    logic [31:0] pc, pc4, instr, w_pc, w_pc4, w_instr;
    logic        instr_valid, w_valid;
    logic [1:0]  fetch_err, w_err;

    int n_tests = 0;
    int n_fail  = 0;

    // model of the main DUT (RESET_PC = 0)
    bit          m_in_reset;
    bit          m_valid;
    bit          m_halted;
    int          m_wait;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [1:0]  m_err;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(32'h0000_0000), .IMEM_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstn(rstn),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .NPCOp(npc_op), .IMM(imm), .RS1(rs1), .advance(advance),
        .PC(pc), .PC4(pc4), .instr(instr), .instr_valid(instr_valid),
        .fetch_err(fetch_err)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC), .IMEM_TIMEOUT(TIMEOUT)) u_wrap (
        .clk(clk), .rstn(rstn),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .NPCOp(npc_op), .IMM(imm), .RS1(rs1), .advance(advance),
        .PC(w_pc), .PC4(w_pc4), .instr(w_instr), .instr_valid(w_valid),
        .fetch_err(w_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_target(input logic [31:0] cur, input logic [2:0] op,
                                                 input logic [31:0] im, input logic [31:0] r1);
        logic [31:0] t;
        case (op)
            3'd1, 3'd2: t = cur + im;
            3'd4: begin
                t = r1 + im;
                t[0] = 1'b0;
            end
            default: t = cur + 32'd4;
        endcase
        return t;
    endfunction

    task automatic model_reset();
        m_in_reset = 1;
        m_valid    = 0;
        m_halted   = 0;
        m_wait     = 0;
        m_pc       = 32'h0;
        m_instr    = 32'h13;
        m_err      = 2'b00;
    endtask

    // Predicts the effect of the coming rising edge given the inputs now applied.
    task automatic model_step();
        logic [31:0] nxt;
        if (m_in_reset) begin
            m_in_reset = 0;
        end else if (m_halted) begin
        end else if (!m_valid) begin
            if (imem_ready) begin
                m_instr = imem_rdata;
                m_valid = 1;
                m_wait  = 0;
            end else begin
                m_wait++;
                if (m_wait == TIMEOUT) begin
                    m_halted = 1;
                    m_err    = 2'b10;
                end
            end
        end else if (advance) begin
            nxt = model_target(m_pc, npc_op, imm, rs1);
            m_valid = 0;
            if (nxt[1:0] != 2'b00) begin
                m_halted = 1;
                m_err    = 2'b01;
            end else begin
                m_pc   = nxt;
                m_wait = 0;
            end
        end
    endtask

    task automatic check_outputs();
        bit exp_req;
        exp_req = !m_in_reset && !m_halted && !m_valid;
        check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        if (exp_req) check("imem_addr", imem_addr, m_pc);
        check("pc", pc, m_pc);
        check("pc4", pc4, m_pc + 32'd4);
        check("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
        if (m_valid || m_in_reset) check("instr", instr, m_instr);
        check("fetch_err", {30'b0, fetch_err}, {30'b0, m_err});
    endtask

    task automatic cycle(input logic rdy, input logic [31:0] rd, input logic adv,
                         input logic [2:0] op, input logic [31:0] im, input logic [31:0] r1);
        imem_ready = rdy;
        imem_rdata = rd;
        advance    = adv;
        npc_op     = op;
        imm        = im;
        rs1        = r1;
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic fetch(input logic [31:0] rd);
        cycle(1'b1, rd, 1'b0, 3'd0, 32'h0, 32'h0);
    endtask

    task automatic step(input logic [2:0] op, input logic [31:0] im, input logic [31:0] r1);
        cycle(1'b0, 32'h0, 1'b1, op, im, r1);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        imem_ready = 1'b0;
        advance = 1'b0;
        model_reset();
        @(negedge clk);
        check_outputs();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pct;
        int r;
        int k;
        logic [2:0] op;
        logic [31:0] im, r1;

        // sequential PLUS4 fetches; wrap-around instance checked alongside
        do_reset();
        cycle(1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 32'h0);
        check("first_addr", imem_addr, 32'h0);
        check("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
        fetch(32'h0050_0093);
        check("first_valid", {31'b0, instr_valid}, 32'd1);
        check("wrap_valid", {31'b0, w_valid}, 32'd1);
        step(3'd0, 32'h0, 32'h0);
        check("second_addr", imem_addr, 32'h4);
        check("wrap_second_addr", w_addr, 32'h0);
        check("wrap_err", {30'b0, w_err}, 32'h0);
        fetch(32'h0050_0093);
        step(3'd0, 32'h0, 32'h0);
        check("third_addr", imem_addr, 32'h8);

        // branch / jump / jalr targets
        fetch(32'h1); step(3'd2, 32'h8, 32'h0);
        check("jump_to_10", imem_addr, 32'h10);
        fetch(32'h2); step(3'd1, 32'hFFFF_FFF8, 32'h0);
        check("branch_minus8", imem_addr, 32'h08);
        fetch(32'h3); step(3'd2, 32'h8, 32'h0);
        fetch(32'h4); step(3'd2, 32'h100, 32'h0);
        check("jump_plus100", imem_addr, 32'h110);
        fetch(32'h5); step(3'd1, 32'h20 - 32'h110, 32'h0);
        fetch(32'h6); step(3'd4, 32'h4, 32'h1001);
        check("jalr_bit0", imem_addr, 32'h1004);
        fetch(32'h7); step(3'd2, 32'h20 - 32'h1004, 32'h0);
        fetch(32'h8); step(3'd4, 32'h0, 32'h1002);
        check("misalign_err", {30'b0, fetch_err}, 32'h1);
        check("misalign_pc", pc, 32'h20);
        check("misalign_req", {31'b0, imem_req}, 32'h0);

        // imem timeout
        do_reset();
        cycle(1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 32'h0);
        repeat (TIMEOUT - 1) cycle(1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 32'h0);
        check("pre_timeout_req", {31'b0, imem_req}, 32'h1);
        check("pre_timeout_err", {30'b0, fetch_err}, 32'h0);
        cycle(1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 32'h0);
        check("timeout_err", {30'b0, fetch_err}, 32'h2);
        check("timeout_req", {31'b0, imem_req}, 32'h0);
        repeat (4) cycle(1'b1, 32'hDEAD_BEEF, 1'b1, 3'd0, 32'h0, 32'h0);
        check("halt_valid", {31'b0, instr_valid}, 32'h0);
        check("halt_err", {30'b0, fetch_err}, 32'h2);

        // asynchronous reset during ISSUE
        do_reset();
        cycle(1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 32'h0);
        fetch(32'h1234_5678);
        step(3'd2, 32'h40, 32'h0);
        fetch(32'h9ABC_DEF0);
        #3 rstn = 1'b0;
        #1;
        check("async_valid", {31'b0, instr_valid}, 32'h0);
        check("async_pc", pc, 32'h0);
        check("async_instr", instr, 32'h13);
        check("async_req", {31'b0, imem_req}, 32'h0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        cycle(1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 32'h0);
        check("post_reset_addr", imem_addr, 32'h0);

        // randomized episodes
        for (int ep = 0; ep < 30; ep++) begin
            r = $urandom_range(0, 9);
            pct = (r == 0) ? 0 : (r < 4) ? 30 : (r < 7) ? 80 : 100;
            do_reset();
            for (int c = 0; c < 80; c++) begin
                r = $urandom_range(0, 9);
                if (r < 4)       op = 3'd0;
                else if (r < 6)  op = 3'd1;
                else if (r < 8)  op = 3'd2;
                else if (r == 8) op = 3'd4;
                else             op = ($urandom_range(0, 1) == 0) ? 3'd3 : 3'($urandom_range(5, 7));
                k  = int'($urandom_range(0, 64)) - 32;
                im = ($urandom_range(0, 19) == 0) ? $urandom : 32'(k * 4);
                r1 = $urandom & 32'hFFFF_FFFC;
                if ($urandom_range(0, 4) == 0) r1 = r1 | 32'($urandom_range(1, 3));
                cycle(($urandom_range(0, 99) < pct) ? 1'b1 : 1'b0, $urandom,
                      1'($urandom_range(0, 1)), op, im, r1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000: address of the first fetch after reset.
REQ-002 The block SHALL have parameter IMEM_TIMEOUT, default 16: maximum wait cycles for imem_ready before an error is raised.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rstn  in  1  asynchronous active-low reset.
REQ-006 imem_req  out  1  instruction memory read request.
REQ-007 imem_addr  out  32  instruction fetch address.
REQ-008 imem_rdata  in  32  instruction word, valid when imem_ready=1.
REQ-009 imem_ready  in  1  memory accepted the request and returned data this cycle.
REQ-010 NPCOp  in  3  next-PC operation from the control decoder: PLUS4 000, BRANCH 001, JUMP 010, JALR 100.
REQ-011 IMM  in  32  sign-extended immediate from the extender.
REQ-012 RS1  in  32  register rs1 value, used for JALR.
REQ-013 advance  in  1  downstream has retired the current instruction.
REQ-014 PC  out  32  address of the instruction in instr.
REQ-015 PC4  out  32  PC+4, the link value for WDSel_FromPC.
REQ-016 instr  out  32  instruction register.
REQ-017 instr_valid  out  1  instr and PC hold an unretired instruction.
REQ-018 fetch_err  out  2  sticky error code: 00 none, 01 misaligned target, 10 imem timeout.

Function
REQ-019 The FSM SHALL have exactly four states: FETCH, ISSUE, HALT, and RESET, where RESET exists only while rstn=0.
REQ-020 FETCH: imem_req=1 and imem_addr=PC; on imem_ready=1, instr<=imem_rdata and the state goes to ISSUE on the next cycle.
REQ-021 imem_addr SHALL stay stable while imem_req=1; imem_ready arriving in the first request cycle SHALL be accepted, giving a latency of 1 cycle from request to instr_valid.
REQ-022 A wait counter SHALL count FETCH cycles with imem_ready=0; when it reaches IMEM_TIMEOUT, fetch_err<=10 and the state goes to HALT.
REQ-023 ISSUE: instr_valid=1 and imem_req=0; instr and PC SHALL stay stable until advance=1.
REQ-024 On advance=1 in ISSUE, the next PC SHALL be computed by NPCOp:
  - PLUS4: PC+4.
  - BRANCH: PC+IMM.
  - JUMP: PC+IMM.
  - JALR: (RS1+IMM) with bit0 cleared.
  - Any other NPCOp value: PC+4.
REQ-025 After the next PC is computed, PC<=next PC and the state SHALL go to FETCH.
REQ-026 All address arithmetic SHALL be modulo 2^32; for example, PC=32'hFFFF_FFFC with PLUS4 wraps to 0 with no error.
REQ-027 If next PC[1:0]!=00, then PC SHALL be unchanged, fetch_err<=01, instr_valid<=0, and the state goes to HALT.
REQ-028 HALT: imem_req=0, instr_valid=0, all inputs ignored, remain in HALT until reset.
REQ-029 advance SHALL be ignored outside ISSUE.
REQ-030 imem_ready SHALL be ignored outside FETCH.
REQ-031 PC4 SHALL equal PC+4 combinationally in every state.

Reset
REQ-032 While rstn=0: PC=RESET_PC, instr=32'h0000_0013 (nop), instr_valid=0, imem_req=0, fetch_err=00, wait counter=0.
REQ-033 On the first rising clk edge after rstn deasserts, the state SHALL be FETCH with imem_req=1 and imem_addr=RESET_PC.
REQ-034 Reset asserted mid-FETCH or mid-ISSUE SHALL abort that fetch or instruction immediately, with no partial update surviving.

Structure
REQ-035 The NPC_* encodings SHALL live in the shared ctrl_encode_def.v header, and the block SHALL NOT redefine them locally.
REQ-036 The FSM state encodings and the fetch_err codes SHALL be added to the same shared header.
REQ-037 Next-PC arithmetic SHALL be a combinational sub-module named npc (inputs PC, NPCOp, IMM, RS1; output NPC); the FSM, registers and timeout counter stay in if_stage.

Verification
REQ-038 Reset then imem_ready=1 every cycle, rdata=32'h00500093, advance pulsed with NPCOp=000 -> fetches at 0x0, then 0x4, then 0x8; instr_valid one cycle after each request.
REQ-039 PC=0x10, BRANCH, IMM=-8 -> next imem_addr=0x08; JUMP with IMM=0x100 -> 0x110.
REQ-040 PC=0x20, JALR, RS1=0x1001, IMM=0x4 -> imem_addr=0x1004 (bit0 cleared); RS1=0x1002, IMM=0 -> fetch_err=01, HALT, PC stays 0x20.
REQ-041 imem_ready held 0 for 16 cycles -> fetch_err=10, imem_req drops, later imem_ready and advance have no effect.
REQ-042 rstn pulsed low while instr_valid=1 -> instr_valid=0 immediately, next fetch at RESET_PC.
REQ-043 RESET_PC=32'hFFFF_FFFC with PLUS4 -> second fetch at 0x0 with fetch_err=00.
